// File: rtl/cnt_run_arbiter.sv
// cnt_run_arbiter: round-robin arbiter that grants one requester a counted run of len cycles on a shared counter
//   clk, reset   : clock, asynchronous active-high reset
//   req, len     : per-requester run request (level) and run length (requester i at [i*CW +: CW])
//   abort        : early termination of the current run
//   gnt, busy    : one-hot grant (LOAD/RUN), FSM not idle
//   count        : shared run counter
//   done, done_id: one-cycle completion pulse and the completing requester
module cnt_run_arbiter #(
  parameter int NREQ = 4,
  parameter int CW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*CW-1:0] len,
  input  logic              abort,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic [CW-1:0]     count,
  output logic              done,
  output logic [1:0]        done_id
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state;
  logic [1:0] last, idx, pick;
  logic [CW-1:0] len_q, len_sel;
  logic stop;
  // Scan downward from the lowest priority so the first set bit after last is what remains.
  always_comb begin
    pick = last;
    for (int k = NREQ; k >= 1; k--) pick = req[last + 2'(k)] ? last + 2'(k) : pick;
  end
  assign len_sel = len[idx*CW +: CW];
  assign stop = abort | ~req[idx];
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      gnt <= '0;
      count <= '0;
      done <= 1'b0;
      done_id <= '0;
      last <= 2'(NREQ - 1);
      idx <= '0;
      len_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          idx <= pick;
          gnt <= NREQ'(1) << pick;
          state <= LOAD;
        end
        LOAD: if (stop) begin
          state <= IDLE;
          gnt <= '0;
          last <= idx;
        end else begin
          len_q <= len_sel;
          count <= '0;
          state <= len_sel != '0 ? RUN : DONE;
          if (len_sel == '0) begin
            gnt <= '0;
            done <= 1'b1;
            done_id <= idx;
          end
        end
        RUN: if (stop) begin
          state <= IDLE;
          gnt <= '0;
          last <= idx;
        end else begin
          count <= count + CW'(1);
          if (count == len_q - CW'(1)) begin
            state <= DONE;
            gnt <= '0;
            done <= 1'b1;
            done_id <= idx;
          end
        end
        default: begin
          last <= idx;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/cnt_run_arbiter.md
CNT_RUN_ARBITER -- requirements
Module: cnt_run_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters; fixed at 4, so done_id is 2 bits.
REQ-002 Parameter CW, default 8: width of the shared counter and of each run length.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 req  input  NREQ  per-requester run request; level, held until done or withdrawn.
REQ-006 len  input  NREQ*CW  per-requester run length; requester i at bits [i*CW +: CW].
REQ-007 abort  input  1  global early termination of the current run.
REQ-008 gnt  output  NREQ  one-hot grant; registered.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 count  output  CW  shared counter value; registered.
REQ-011 done  output  1  single-cycle completion pulse.
REQ-012 done_id  output  2  index of the completing requester; valid while done=1.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, LOAD, RUN, DONE.
REQ-014 IDLE: if any req bit is 1, the block SHALL select one requester by round-robin, set gnt to that requester's bit, and move to LOAD on the next edge; otherwise it SHALL stay in IDLE.
REQ-015 Round-robin: the search SHALL start at index (last+1) mod NREQ and take the first set req bit, where last is the most recently granted index; the search SHALL wrap from NREQ-1 to 0.
REQ-016 LOAD: the block SHALL latch len of the granted requester into an internal register and clear count to 0.
- latched length nonzero -> next state RUN.
- latched length zero -> next state DONE.
REQ-017 LOAD: changes on len after LOAD SHALL NOT affect the current run.
REQ-018 RUN: count SHALL increment by 1 every cycle.
- when count equals latched length minus 1, next state SHALL be DONE.
- count therefore equals the latched length in DONE, and RUN lasts exactly latched-length cycles.
REQ-019 Counter arithmetic SHALL be CW-bit unsigned; count SHALL never wrap within a run, because the maximum length is 2^CW-1.
REQ-020 gnt SHALL be asserted in LOAD and RUN, and SHALL be 0 in IDLE and DONE.
REQ-021 DONE: done SHALL be 1 and done_id SHALL equal the granted index for exactly one cycle; last SHALL update to the granted index; next state SHALL be IDLE.
REQ-022 Latency: a req sampled in IDLE at edge n SHALL give gnt at n+1 and done at n+2+len; with len=0, done SHALL occur at n+2.
REQ-023 Withdrawal: if the granted requester's req bit is 0 in LOAD or RUN, the next state SHALL be IDLE.
- done SHALL remain 0 and gnt SHALL clear.
- last SHALL still update to the withdrawn index.
REQ-024 Abort: abort=1 in LOAD or RUN SHALL act identically to REQ-023.
- abort in IDLE or DONE SHALL be ignored.
REQ-025 Simultaneous events: abort or withdrawal in the same cycle as the final RUN count SHALL win over completion, so no done pulse is produced.
REQ-026 Requests arriving in LOAD, RUN or DONE SHALL be arbitrated only after the FSM returns to IDLE; there SHALL be at least one IDLE cycle between consecutive grants.
REQ-027 count SHALL hold its last value in IDLE and DONE until the next LOAD.

Reset
REQ-028 On reset assertion, immediately and independently of clk, the block SHALL set:
- state = IDLE
- gnt = 0, count = 0, done = 0, done_id = 0, busy = 0
- last = NREQ-1, so requester 0 has first priority.
REQ-029 Reset asserted mid-run SHALL discard the run with no done pulse; after release the block SHALL re-arbitrate from IDLE.

Verification
REQ-030 Single run: req=0001, len0=3 -> gnt=0001 at cycle 1; RUN cycles 2-4 with count 0,1,2; cycle 5 done=1, done_id=0, count=3; cycle 6 busy=0.
REQ-031 Round-robin: req=1111 held, all len=1 -> grant order 0,1,2,3,0 with done_id in the same sequence; no requester is granted twice in a row.
REQ-032 Zero length: req=0100, len2=0 -> gnt=0100 for one cycle, then done=1, done_id=2, count=0.
REQ-033 Abort: req=0010, len1=10, abort pulsed when count=4 -> next cycle IDLE, gnt=0, done never asserted; the next grant from req=0011 goes to requester 0 (wrap past last=1).
REQ-034 Abort/complete tie: len0=2, abort=1 in the cycle count=1 -> no done pulse; state IDLE.
REQ-035 Async reset mid-RUN: reset asserted between edges -> outputs zero before the next edge; after release, req=1000 is granted at the first eligible edge.
